conv_writeback_ctrl: RTL

CONV_WRITEBACK_CTRL -- requirements
Module: conv_writeback_ctrl

---
 rtl/conv_writeback_ctrl_pkg.sv | 18 +
 rtl/conv_writeback_ctrl_fifo.sv | 69 ++++++
 rtl/conv_writeback_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/conv_writeback_ctrl_pkg.sv
// Shared definitions for the convolution write-back controller.
//   - wb_state_t : frame sequencer state encoding (IDLE, RUN, DRAIN, DONE)
//   - DEFAULT_FIFO_DEPTH / DEFAULT_ADDR_W : default top-level parameters
//   - DATA_W : width of a result word and of an SRAM write word
package conv_writeback_ctrl_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int DEFAULT_ADDR_W     = 12;
  localparam int DATA_W             = 16;

  typedef logic [1:0] wb_state_t;

  localparam wb_state_t ST_IDLE  = 2'd0;
  localparam wb_state_t ST_RUN   = 2'd1;
  localparam wb_state_t ST_DRAIN = 2'd2;
  localparam wb_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/conv_writeback_ctrl_fifo.sv
// wb_fifo: synchronous result buffer for the write-back controller.
// Ports:
//   clk      - clock, rising edge
//   clr_n_i  - asynchronous active-low clear (empties the buffer)
//   push_i   - write wdata_i (ignored when full)
//   pop_i    - drop the head entry (ignored when empty)
//   wdata_i  - entry to store
//   rdata_o  - current head entry (valid when not empty)
//   count_o  - number of stored entries
//   full_o / empty_o - occupancy flags
module wb_fifo
  import conv_writeback_ctrl_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter  int WIDTH = DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clr_n_i) begin
    if (!clr_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the cleared count marks every
  // entry invalid, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/conv_writeback_ctrl.sv
// conv_writeback_ctrl: buffers convolution results and writes them to SRAM
// at consecutive addresses starting from a per-frame base address.
// Build option: define WB_PACK_EN to pack pairs of 8-bit results into one
// 16-bit word (first byte high); otherwise each result is one word.
// Ports:
//   clk, reset_b            - clock (rising edge), async active-low reset
//   wb_start, wb_base_addr  - frame start pulse and first write address
//   res_valid/data/last     - result stream in; res_ready is the handshake
//   dut_sram_write_*        - registered SRAM write port
//   wb_busy, wb_done, wb_wrap - frame status (wrap is sticky per frame)
module conv_writeback_ctrl
  import conv_writeback_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_W     = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              wb_start,
  input  logic [ADDR_W-1:0] wb_base_addr,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_last,
  output logic              res_ready,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              wb_busy,
  output logic              wb_done,
  output logic              wb_wrap
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  wb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_en_q;
  logic              wrap_q;

  logic              accept;
  logic              start_ok;
  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_wdata;
  logic [DATA_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  // Ready depends only on registered state, never on res_valid. A pop in the
  // same cycle does not reopen a full buffer.
  assign res_ready = (state_q == ST_RUN) && !fifo_full;
  assign accept    = res_valid && res_ready;
  assign start_ok  = (state_q == ST_IDLE) && wb_start;
  assign fifo_pop  = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !fifo_empty;

`ifdef WB_PACK_EN
  logic [7:0] pack_hi_q;
  logic       pack_have_q;
  logic       unused_res_hi;

  assign unused_res_hi = ^res_data[15:8];
  // A word is pushed on the second byte of a pair, or on a lone last byte.
  assign fifo_push  = accept && (pack_have_q || res_last);
  assign fifo_wdata = pack_have_q ? {pack_hi_q, res_data[7:0]}
                                  : {res_data[7:0], 8'h00};

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      pack_hi_q   <= '0;
      pack_have_q <= 1'b0;
    end else if (start_ok) begin
      pack_have_q <= 1'b0;
    end else if (accept) begin
      if (pack_have_q || res_last) begin
        pack_have_q <= 1'b0;
      end else begin
        pack_hi_q   <= res_data[7:0];
        pack_have_q <= 1'b1;
      end
    end
  end
`else
  assign fifo_push  = accept;
  assign fifo_wdata = res_data;
`endif

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .clr_n_i (reset_b),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (wb_start) state_d = ST_RUN;
      ST_RUN:   if (accept && res_last) state_d = ST_DRAIN;
      ST_DRAIN: if ((fifo_count == '0) && !fifo_pop) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= ST_IDLE;
      addr_cnt_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= fifo_pop;
      if (start_ok) begin
        addr_cnt_q <= wb_base_addr;
        wrap_q     <= 1'b0;
      end else if (fifo_pop) begin
        wr_addr_q  <= addr_cnt_q;
        wr_data_q  <= fifo_rdata;
        addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
        if (&addr_cnt_q) wrap_q <= 1'b1;
      end
    end
  end

  assign dut_sram_write_enable  = wr_en_q;
  assign dut_sram_write_address = wr_addr_q;
  assign dut_sram_write_data    = wr_data_q;
  assign wb_busy                = (state_q != ST_IDLE);
  assign wb_done                = (state_q == ST_DONE);
  assign wb_wrap                = wrap_q;

endmodule
